// File: rtl/generator_stare_afisaj_pkg.sv
// Shared types for the display status generator: FSM states, BCD digit width
// and the two-digit run-timer increment.
package generator_stare_afisaj_pkg;

  typedef enum logic [1:0] {
    OPRIT   = 2'd0,
    INAINTE = 2'd1,
    STANGA  = 2'd2,
    DREAPTA = 2'd3
  } stare_t;

  localparam int                BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic [BCD_W-1:0] zeci;
    logic [BCD_W-1:0] unitati;
  } timp_t;

  // 00..99 seconds, 99 wraps to 00
  function automatic timp_t timp_inc(input timp_t t);
    timp_t r;
    r = t;
    if (t.unitati == BCD_MAX) begin
      r.unitati = '0;
      r.zeci    = (t.zeci == BCD_MAX) ? '0 : t.zeci + 1'b1;
    end else begin
      r.unitati = t.unitati + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/generator_stare_afisaj_filtru.sv
// 2-FF synchroniser followed by a stability filter: the output follows the
// synchronised input only after it has differed for DEB_CYCLES consecutive cycles.
module filtru_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_raw,
  output logic out_filt
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      cnt      <= '0;
      out_filt <= 1'b0;
    end else begin
      sync <= {sync[0], in_raw};
      // any return to the filtered value restarts the count
      if (sync[1] != out_filt) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          out_filt <= sync[1];
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/generator_stare_afisaj.sv
// Turns the line sensors and start/stop button into the display driver's
// status: blinking turn indicators, stop flag and a two-digit BCD run timer.
module generator_stare_afisaj
  import generator_stare_afisaj_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 50000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             senzor_stanga,
  input  logic             senzor_dreapta,
  input  logic             buton_start,
  output logic             semnal_stanga,
  output logic             semnal_dreapta,
  output logic             stop,
  output logic [BCD_W-1:0] cifra_zeci,
  output logic [BCD_W-1:0] cifra_unitati
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [2:0] raw, filt;
  logic       buton_prev, start_p;
  stare_t     stare, stare_next;

  logic [TW-1:0] presc, presc_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          faza, faza_d;
  timp_t         timp, timp_d;
  logic          stop_d, stanga_d, dreapta_d;

  assign raw = {buton_start, senzor_dreapta, senzor_stanga};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    filtru_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .in_raw  (raw[i]),
      .out_filt(filt[i])
    );
  end

  assign start_p = filt[2] & ~buton_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stare <= OPRIT;
    else          stare <= stare_next;
  end

  always_comb begin
    stare_next = stare;
    if (stare == OPRIT) begin
      if (start_p) stare_next = INAINTE;
    end else if (start_p) begin
      stare_next = OPRIT;
    end else begin
      case (filt[1:0])
        2'b01:   stare_next = STANGA;
        2'b10:   stare_next = DREAPTA;
        default: stare_next = INAINTE;
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    faza_d      = 1'b0;
    if (stare_next == STANGA || stare_next == DREAPTA) begin
      // every entry, including a direct left<->right swap, starts ON
      if (stare_next != stare) begin
        faza_d = 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        faza_d = ~faza;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
        faza_d      = faza;
      end
    end

    presc_d = presc;
    timp_d  = timp;
    if (stare == OPRIT) begin
      presc_d = '0;
      if (start_p) timp_d = '0;
    end else if (presc == TW'(TICK_DIV - 1)) begin
      presc_d = '0;
      timp_d  = timp_inc(timp);
    end else begin
      presc_d = presc + 1'b1;
    end

    stop_d    = (stare_next == OPRIT);
    stanga_d  = (stare_next == STANGA)  & faza_d;
    dreapta_d = (stare_next == DREAPTA) & faza_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buton_prev     <= 1'b0;
      presc          <= '0;
      blink_cnt      <= '0;
      faza           <= 1'b0;
      timp           <= '0;
      stop           <= 1'b1;
      semnal_stanga  <= 1'b0;
      semnal_dreapta <= 1'b0;
    end else begin
      buton_prev     <= filt[2];
      presc          <= presc_d;
      blink_cnt      <= blink_cnt_d;
      faza           <= faza_d;
      timp           <= timp_d;
      stop           <= stop_d;
      semnal_stanga  <= stanga_d;
      semnal_dreapta <= dreapta_d;
    end
  end

  assign cifra_zeci    = timp.zeci;
  assign cifra_unitati = timp.unitati;

endmodule

// File: tb/tb_generator_stare_afisaj.sv
// Directed + random bench for generator_stare_afisaj against a cycle-level
// behavioural model (elapsed-cycle arithmetic for blink and timer).
module tb_generator_stare_afisaj;

  localparam int DEB   = 3;
  localparam int TICK  = 10;
  localparam int BLINK = 4;

  localparam int M_OFF = 0, M_FWD = 1, M_LEFT = 2, M_RIGHT = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       senzor_stanga = 1'b0, senzor_dreapta = 1'b0, buton_start = 1'b0;
  logic       semnal_stanga, semnal_dreapta, stop;
  logic [3:0] cifra_zeci, cifra_unitati;

  int vectors = 0, miscompares = 0;

  // model state
  int m_s1[3], m_s2[3], m_filt[3], m_run[3];
  int m_btn_prev, m_state, m_age, m_n;

  always #5 clock = ~clock;

  generator_stare_afisaj #(.DEB_CYCLES(DEB), .TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .senzor_stanga (senzor_stanga),
    .senzor_dreapta(senzor_dreapta),
    .buton_start   (buton_start),
    .semnal_stanga (semnal_stanga),
    .semnal_dreapta(semnal_dreapta),
    .stop          (stop),
    .cifra_zeci    (cifra_zeci),
    .cifra_unitati (cifra_unitati)
  );

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_run[i] = 0;
    end
    m_btn_prev = 0; m_state = M_OFF; m_age = 0; m_n = 0;
  endtask

  task automatic model_edge();
    int raw[3];
    int nxt;
    bit start_p;
    if (!reset_n) begin
      model_reset();
      return;
    end
    raw[0] = int'(senzor_stanga); raw[1] = int'(senzor_dreapta); raw[2] = int'(buton_start);
    start_p = (m_filt[2] == 1) && (m_btn_prev == 0);
    if (m_state == M_OFF)                 nxt = start_p ? M_FWD : M_OFF;
    else if (start_p)                     nxt = M_OFF;
    else if (m_filt[0] == 1 && m_filt[1] == 0) nxt = M_LEFT;
    else if (m_filt[0] == 0 && m_filt[1] == 1) nxt = M_RIGHT;
    else                                  nxt = M_FWD;
    // run time in cycles since the last start
    if (m_state == M_OFF) begin
      if (start_p) m_n = 0;
    end else begin
      m_n++;
    end
    if (nxt == M_LEFT || nxt == M_RIGHT) m_age = (nxt != m_state) ? 0 : m_age + 1;
    m_state    = nxt;
    m_btn_prev = m_filt[2];
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_filt[i] = m_s2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic check_all();
    int sec;
    bit on;
    sec = (m_n / TICK) % 100;
    on  = ((m_age / BLINK) % 2) == 0;
    chk("stop",    8'(stop),           8'(m_state == M_OFF));
    chk("stanga",  8'(semnal_stanga),  8'(m_state == M_LEFT  && on));
    chk("dreapta", 8'(semnal_dreapta), 8'(m_state == M_RIGHT && on));
    chk("zeci",    8'(cifra_zeci),     8'(sec / 10));
    chk("unitati", 8'(cifra_unitati),  8'(sec % 10));
    chk("excl",    8'(semnal_stanga & semnal_dreapta), 8'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int lat;
    model_reset();

    // reset held while the button toggles
    for (int k = 0; k < 4; k++) begin
      buton_start = k[0];
      tick();
    end
    buton_start = 1'b0;
    chk("rst_stop", 8'(stop), 8'd1);
    reset_n = 1'b1;
    ticks(10);

    // bouncing button, then held: one start, stop falls DEB+3 edges after last edge
    buton_start = 1'b1; tick();
    buton_start = 1'b0; tick();
    buton_start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lat == 0 && stop == 1'b0) lat = k;
    end
    chk("start_latency", 8'(lat), 8'(DEB + 3));
    buton_start = 1'b0;
    ticks(10);

    // left turn latency and blink
    senzor_stanga = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (lat == 0 && semnal_stanga == 1'b1) lat = k;
    end
    chk("left_latency", 8'(lat), 8'(DEB + 3));
    ticks(16);

    // direct left->right, then both sensors
    senzor_stanga = 1'b0; senzor_dreapta = 1'b1;
    ticks(20);
    senzor_stanga = 1'b1;
    ticks(10);
    chk("both_fwd_l", 8'(semnal_stanga),  8'd0);
    chk("both_fwd_r", 8'(semnal_dreapta), 8'd0);
    senzor_stanga = 1'b0; senzor_dreapta = 1'b0;

    // timer wrap over 100 seconds
    ticks(1010);

    // stop at 42 s
    for (int k = 0; k < 2000 && !(m_n % 1000 == 420); k++) tick();
    buton_start = 1'b1;
    ticks(12);
    chk("stop42", 8'(stop), 8'd1);
    chk("frz_zeci", 8'(cifra_zeci), 8'd4);
    chk("frz_unit", 8'(cifra_unitati), 8'd2);
    buton_start = 1'b0;
    ticks(15);

    // restart: digits cleared, first increment after TICK cycles
    buton_start = 1'b1;
    lat = 0;
    for (int k = 0; k < 20 && stop == 1'b1; k++) tick();
    chk("restart_z", 8'(cifra_zeci), 8'd0);
    chk("restart_u", 8'(cifra_unitati), 8'd0);
    ticks(TICK - 1);
    chk("pre_tick", 8'(cifra_unitati), 8'd0);
    tick();
    chk("first_tick", 8'(cifra_unitati), 8'd1);
    buton_start = 1'b0;
    ticks(30);

    // random sensor / button activity
    for (int seg = 0; seg < 300; seg++) begin
      int hold;
      senzor_stanga  = 1'($urandom_range(0, 1));
      senzor_dreapta = 1'($urandom_range(0, 1));
      buton_start    = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 12);
      ticks(hold);
      buton_start = 1'b0;
    end

    // asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    ticks(2);
    reset_n = 1'b1;
    buton_start = 1'b1;
    ticks(12);
    buton_start = 1'b0;
    senzor_dreapta = 1'b1;
    ticks(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/generator_stare_afisaj.md
Name: generator_stare_afisaj

Overview:
- Producer side of the multiplexed 7-segment display interface. Turns the two raw line sensors and a start/stop push-button into the display status signals:
  - semnal_stanga / semnal_dreapta: blinking turn indicators.
  - stop
  - cifra_zeci / cifra_unitati: two-digit BCD run timer.
- Sits between the sensor/button pins and the display driver; all outputs connect 1:1 to the display driver inputs of the same names.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles before a synchronised input is accepted (10 ms at 50 MHz).
- TICK_DIV, 50000000, clock cycles per timer second.
- BLINK_DIV, 12500000, clock cycles per blink half-period.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- senzor_stanga  in  1  raw left line sensor, 1 = line seen, asynchronous
- senzor_dreapta  in  1  raw right line sensor, 1 = line seen, asynchronous
- buton_start  in  1  raw push-button, 1 = pressed, asynchronous
- semnal_stanga  out  1  left turn indicator, blinking
- semnal_dreapta  out  1  right turn indicator, blinking
- stop  out  1  car stopped; display shows 8888
- cifra_zeci  out  4  BCD tens of seconds running, 0-9
- cifra_unitati  out  4  BCD units of seconds running, 0-9

Behaviour:
- Reset, asynchronous on reset_n=0, mid-operation included:
  - state = OPRIT, stop=1, semnal_stanga=0, semnal_dreapta=0, cifra_zeci=0, cifra_unitati=0.
  - All counters and synchroniser/debounce registers are cleared to 0.
- Input conditioning, per input:
  - 2-FF synchroniser, then debounce filter.
  - The filtered value takes the synchronised value once that value has differed from the filtered value for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- Button: a rising edge of the filtered button gives a 1-cycle pulse, start_p.
- FSM, states OPRIT, INAINTE, STANGA, DREAPTA. Let (L,R) be the filtered sensors.
  - OPRIT: start_p -> INAINTE and timer cleared to 00.
  - Run states, any of INAINTE, STANGA, DREAPTA:
    - start_p -> OPRIT, with priority over any sensor change in the same cycle.
    - Otherwise (L,R)=(1,0) -> STANGA; (0,1) -> DREAPTA; (0,0) or (1,1) -> INAINTE.
    - Direct STANGA<->DREAPTA transitions are allowed.
- Outputs are registered and updated in the same edge as the state register.
  - stop = 1 only in OPRIT.
  - semnal_stanga = blink phase in STANGA, else 0. semnal_dreapta = blink phase in DREAPTA, else 0.
  - Never both 1 at once.
- Latency, raw sensor edge to indicator change: exactly DEB_CYCLES+3 clock edges, with stable input and no button activity.
- Blink:
  - Phase counter 0..BLINK_DIV-1.
  - Reloads to 0 with phase=1 on every entry into STANGA or DREAPTA, including a direct STANGA<->DREAPTA change.
  - The first half-period is therefore ON. Phase toggles each time the counter wraps.
- Timer:
  - Prescaler 0..TICK_DIV-1 runs only in run states. It is held at 0 in OPRIT and cleared on OPRIT->INAINTE.
  - On prescaler wrap: cifra_unitati increments. At 9 it wraps to 0 and cifra_zeci increments. 99 wraps to 00.
  - Digits freeze in OPRIT and keep their last value. The display shows 8888 in that state regardless.
- Digit values are always valid BCD, 0-9. Codes 10-15 are never driven.

Decomposition:
- Shared package:
  - FSM state encoding: OPRIT=2'd0, INAINTE=2'd1, STANGA=2'd2, DREAPTA=2'd3.
  - BCD digit width of 4.
  - BCD_MAX = 4'd9.
- Sub-module filtru_debounce, parameter DEB_CYCLES; ports clock, reset_n, in_raw, out_filt. Contains the synchroniser and the stability counter. Instantiated three times.

Test Plan (DEB_CYCLES=3, TICK_DIV=10, BLINK_DIV=4):
1. Reset: hold reset_n=0, pulse buton_start -> stop=1, indicators 0, digits 0/0. Release -> outputs unchanged until a button press.
2. Button bounce: 0-1-0-1 at 1-cycle spacing, then held 1 -> exactly one start_p. Stop falls DEB_CYCLES+3 edges after the last raw edge; FSM in INAINTE.
3. Left turn: running, senzor_stanga=1 -> semnal_stanga=1 at edge DEB_CYCLES+3. Then pattern 4 cycles on / 4 off. semnal_dreapta stays 0.
4. Left->right direct: (1,0)->(0,1) -> semnal_stanga drops and semnal_dreapta=1 on the same edge, blink phase restarted ON. (1,1) -> both 0, INAINTE.
5. Timer wrap: run 1000 cycles -> digits count 00..99 then 00; the 9->0 unitati carry increments zeci on the same edge.
6. Stop and restart: button press at 42 s -> stop=1, digits frozen at 4/2. Second press -> digits 0/0, counting resumes after 10 cycles. Reset asserted mid-run -> immediate return to reset values.
